sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Synchronous controller that sequences the set and reset inputs of an external cross-coupled SR latch on behalf of two requesters: a set requester and a clear requester. It guarantees that `s_out` and `r_out` are never high together, produces fixed-width pulses separated by a dead time, and arbitrates simultaneous requests round-robin. After each pulse it checks the latch output `q_in` and flags a mismatch. It sits between control logic and the latch/`q`/`q_bar` pair.

## Interface
- `PULSE_W`, default 2: number of cycles `s_out`/`r_out` is held high; ≥1.
- `DEAD_W`, default 1: number of cycles both drives are held low after a pulse, before `q_in` is checked; ≥1.
- `CNT_W`, default 4: width of the pulse/dead counter; must hold max(PULSE_W, DEAD_W).
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set_req`  in  1  level request to drive the latch to q=1; held until `set_ack`.
- `clr_req`  in  1  level request to drive the latch to q=0; held until `clr_ack`.
- `q_in`  in  1  latch q output, already synchronised.
- `err_clr`  in  1  clears `err`.
- `s_out`  out  1  registered set drive to the latch, active-high.
- `r_out`  out  1  registered reset drive to the latch, active-high.
- `set_ack`  out  1  one-cycle completion pulse for a set operation.
- `clr_ack`  out  1  one-cycle completion pulse for a clear operation.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky flag: `q_in` did not match the target at the check point.

## Operation
- States:
  - **IDLE**: samples requests.
  - **PULSE**: drives `s_out` or `r_out` for PULSE_W cycles.
  - **DEAD**: both drives low for DEAD_W cycles.
  - **ACK**: one cycle, asserts the ack.
- IDLE, one request high: that request is the target.
- IDLE, both requests high: round-robin. The target is the side opposite `last_served`. `last_served` resets to "clear", so set wins the first tie.
- Skip path: if `q_in` already equals the target in IDLE, go directly to ACK with no pulse. This still updates `last_served` and never sets `err`.
- Pulse path: IDLE→PULSE→DEAD→ACK→IDLE.
  - In the last DEAD cycle, the controller compares `q_in` with the target.
  - Mismatch sets `err`; the ack is still issued.
- Only one of `s_out`/`r_out` may be high in any cycle, and only in PULSE.
- `err`:
  - Set by a mismatch.
  - Cleared by `err_clr`.
  - Mismatch and `err_clr` in the same cycle: `err` ends high.
- Requests are sampled only in IDLE. Request changes during PULSE, DEAD or ACK are ignored.
- Reset values: state IDLE; `s_out`, `r_out`, `set_ack`, `clr_ack`, `busy`, `err` all 0; counter 0; `last_served` = clear.
- Reset mid-operation: drives drop immediately (asynchronously), no ack is produced, and the interrupted request is re-arbitrated after release if still held.

## Timing
- Pulse path, request sampled at edge 0:
  - Drive high in cycles 1..PULSE_W.
  - DEAD in cycles PULSE_W+1..PULSE_W+DEAD_W.
  - Ack in cycle PULSE_W+DEAD_W+1, so request-to-ack latency is PULSE_W+DEAD_W+1.
- Skip path: ack in cycle 1 (latency 1).
- After ACK the controller spends at least one IDLE cycle. A requester must deassert on the edge that ends its ack cycle so it is not re-served.
- `busy` is registered and high in cycles 1 through the ack cycle inclusive.

## Test plan
- **Reset**: hold `rst_n`=0 → all outputs 0. Release, then leave all inputs idle 5 cycles → outputs stay 0.
- **Basic set**: `q_in`=0, `set_req`=1, latch model follows `s_out`, PULSE_W=2, DEAD_W=1 → `s_out` high cycles 1–2, low cycle 3, `set_ack` in cycle 4, `err`=0, `r_out` never high.
- **Tie and round-robin**: `set_req`=`clr_req`=1 from reset with the latch model → set served first (ack cycle 4), then clear served (`r_out` high for 2 cycles) after the intervening IDLE cycle. Repeat the tie → set again.
- **Skip and error**: `q_in`=1 with `set_req` → `set_ack` in cycle 1, no `s_out`. Then `clr_req` with `q_in` stuck at 1 → `r_out` pulse, `clr_ack`, `err`=1. `err_clr` → `err`=0. Mismatch coincident with `err_clr` → `err`=1.
- **Reset mid-pulse**: assert `rst_n`=0 during cycle 2 of an `s_out` pulse → `s_out` drops without waiting for an edge, no ack. After release with `set_req` still high → full sequence restarts.
- **Exclusion assertion**: under random requests and random `q_in`, across 10k cycles → `s_out`&`r_out` never both high, and every request receives exactly one ack.

Source files
------------

// File: rtl/sr_latch_driver.sv
// Sequences set/reset drives of an external SR latch for two requesters.
// Drives never overlap, pulses are followed by a dead time, and q_in is checked afterwards.
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int DEAD_W  = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_in,
    input  logic err_clr,
    output logic s_out,
    output logic r_out,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_W - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_set_q, tgt_set_d;
    logic             last_set_q, last_set_d;
    logic             err_q, err_d;
    logic             s_out_q, s_out_d;
    logic             r_out_q, r_out_d;
    logic             set_ack_q, set_ack_d;
    logic             clr_ack_q, clr_ack_d;
    logic             busy_q, busy_d;
    logic             mismatch;

    // Every output is registered from the next state, so a drive asserted in
    // PULSE appears in the cycle after the request was sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tgt_set_q  <= 1'b0;
            last_set_q <= 1'b0;
            err_q      <= 1'b0;
            s_out_q    <= 1'b0;
            r_out_q    <= 1'b0;
            set_ack_q  <= 1'b0;
            clr_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_set_q  <= tgt_set_d;
            last_set_q <= last_set_d;
            err_q      <= err_d;
            s_out_q    <= s_out_d;
            r_out_q    <= r_out_d;
            set_ack_q  <= set_ack_d;
            clr_ack_q  <= clr_ack_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_set_d  = tgt_set_q;
        last_set_d = last_set_q;
        mismatch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_req || clr_req) begin
                    // On a tie, serve the side that was not served last.
                    tgt_set_d  = (set_req && clr_req) ? !last_set_q : set_req;
                    last_set_d = tgt_set_d;
                    cnt_d      = '0;
                    state_d    = (q_in == tgt_set_d) ? ACK : PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = DEAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    mismatch = (q_in != tgt_set_q);
                    cnt_d    = '0;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_out_d   = (state_d == PULSE) && tgt_set_d;
        r_out_d   = (state_d == PULSE) && !tgt_set_d;
        set_ack_d = (state_d == ACK) && tgt_set_d;
        clr_ack_d = (state_d == ACK) && !tgt_set_d;
        busy_d    = (state_d != IDLE);
        // A fresh mismatch wins over a coincident clear.
        err_d     = mismatch || (err_q && !err_clr);
    end

    assign s_out   = s_out_q;
    assign r_out   = r_out_q;
    assign set_ack = set_ack_q;
    assign clr_ack = clr_ack_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch model,
// followed by a random request phase checking drive exclusion and ack counts.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic err_clr = 1'b0;
    logic q_in;
    logic s_out, r_out, set_ack, clr_ack, busy, err;

    logic latch_q = 1'b0;
    logic latch_rst = 1'b0;
    logic q_force_en = 1'b0;
    logic q_force_val = 1'b0;

    int checks = 0;
    int failures = 0;
    int set_iss = 0, set_ack_n = 0, clr_iss = 0, clr_ack_n = 0;

    logic [5:0] outs;
    assign outs = {s_out, r_out, set_ack, clr_ack, busy, err};

    sr_latch_driver #(.PULSE_W(2), .DEAD_W(1), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .clr_req (clr_req),
        .q_in    (q_in),
        .err_clr (err_clr),
        .s_out   (s_out),
        .r_out   (r_out),
        .set_ack (set_ack),
        .clr_ack (clr_ack),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Cross-coupled latch: follows whichever drive is high, otherwise holds.
    always @(s_out, r_out, latch_rst) begin
        if (latch_rst) latch_q = 1'b0;
        else if (s_out) latch_q = 1'b1;
        else if (r_out) latch_q = 1'b0;
    end

    assign q_in = q_force_en ? q_force_val : latch_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        latch_rst = 1'b1;
        #1;
        latch_rst = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Called in IDLE with the request already raised; walks cycles 1..5.
    task automatic run_pulse(input logic is_set, input logic err_pre, input logic err_post,
                             input logic clr_in_dead, input string tag);
        logic [5:0] e;
        tick();
        e = {is_set, !is_set, 2'b00, 1'b1, err_pre};
        chk({tag, "_c1"}, 32'(outs), 32'(e));
        tick();
        chk({tag, "_c2"}, 32'(outs), 32'(e));
        err_clr = clr_in_dead;
        tick();
        e = {4'b0000, 1'b1, err_pre};
        chk({tag, "_c3"}, 32'(outs), 32'(e));
        tick();
        err_clr = 1'b0;
        e = {2'b00, is_set, !is_set, 1'b1, err_post};
        chk({tag, "_c4"}, 32'(outs), 32'(e));
        if (is_set) set_req = 1'b0;
        else clr_req = 1'b0;
        tick();
        e = {5'b00000, err_post};
        chk({tag, "_c5"}, 32'(outs), 32'(e));
    endtask

    task automatic rand_cycle(input logic allow_new);
        tick();
        chk("excl", 32'(s_out & r_out), 32'd0);
        if (set_ack) begin
            chk("set_ack_req", 32'(set_req), 32'd1);
            set_req = 1'b0;
            set_ack_n++;
        end else if (allow_new && !set_req && $urandom_range(3) == 0) begin
            set_req = 1'b1;
            set_iss++;
        end
        if (clr_ack) begin
            chk("clr_ack_req", 32'(clr_req), 32'd1);
            clr_req = 1'b0;
            clr_ack_n++;
        end else if (allow_new && !clr_req && $urandom_range(3) == 0) begin
            clr_req = 1'b1;
            clr_iss++;
        end
        q_force_val = 1'($urandom_range(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        tick();
        chk("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outs", 32'(outs), 32'd0);
        end

        // Basic set with latch following s_out
        set_req = 1'b1;
        run_pulse(1'b1, 1'b0, 1'b0, 1'b0, "basic_set");

        // Tie from reset: set first, then clear, then set again
        do_reset();
        set_req = 1'b1;
        clr_req = 1'b1;
        run_pulse(1'b1, 1'b0, 1'b0, 1'b0, "tie_set");
        run_pulse(1'b0, 1'b0, 1'b0, 1'b0, "tie_clr");
        set_req = 1'b1;
        clr_req = 1'b1;
        run_pulse(1'b1, 1'b0, 1'b0, 1'b0, "rr_set");
        run_pulse(1'b0, 1'b0, 1'b0, 1'b0, "rr_clr");

        // Skip path, stuck latch error, err_clr, and mismatch vs err_clr
        q_force_en = 1'b1;
        q_force_val = 1'b1;
        set_req = 1'b1;
        tick();
        chk("skip_c1", 32'(outs), 32'(6'b001010));
        set_req = 1'b0;
        tick();
        chk("skip_c2", 32'(outs), 32'd0);
        clr_req = 1'b1;
        run_pulse(1'b0, 1'b0, 1'b1, 1'b0, "stuck_clr");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        clr_req = 1'b1;
        run_pulse(1'b0, 1'b0, 1'b1, 1'b1, "clr_vs_mismatch");

        // Reset during the second pulse cycle
        q_force_en = 1'b0;
        do_reset();
        set_req = 1'b1;
        tick();
        chk("mid_c1", 32'(s_out), 32'd1);
        tick();
        chk("mid_c2", 32'(s_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_drop", 32'(outs), 32'd0);
        // Latch assumed not to have flipped from the truncated pulse.
        latch_rst = 1'b1;
        #1;
        latch_rst = 1'b0;
        tick();
        tick();
        chk("mid_no_ack", 32'(outs), 32'd0);
        rst_n = 1'b1;
        run_pulse(1'b1, 1'b0, 1'b0, 1'b0, "mid_restart");

        // Random requests and random q_in
        q_force_en = 1'b1;
        for (int i = 0; i < 10000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 50 && (set_req || clr_req); i++) rand_cycle(1'b0);
        chk("drain_done", 32'({set_req, clr_req}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_extra_ack", 32'({set_ack, clr_ack}), 32'd0);
        end
        chk("set_ack_count", 32'(set_ack_n), 32'(set_iss));
        chk("clr_ack_count", 32'(clr_ack_n), 32'(clr_iss));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
